// File: rtl/eram_resp_pkg.sv
// rtl/eram_resp_pkg.sv - shared types, states and token helpers for the ERAM responder
package eram_resp_pkg;

  localparam int WIDTH_DATA     = 32;
  localparam int WIDTH_LENGTH   = 8;
  localparam int WIDTH_TID      = 8;
  localparam int SKID_DEPTH_DEF = 2;

  // Forward token: valid, acquire, release, T-ID tag, payload
  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic [WIDTH_TID-1:0]  i;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  // Backward token: n = nack/stall; t/v/c are carried but unused here
  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

  typedef enum logic [2:0] {
    RESP_IDLE,
    RESP_FID,
    RESP_ATTR,
    RESP_ROUTE,
    RESP_ST_DATA,
    RESP_LD_ACQ,
    RESP_LD_DATA,
    RESP_LD_DRAIN
  } fsm_eram_resp;

  typedef struct packed {
    logic                    is_pull;
    logic [WIDTH_LENGTH-1:0] length;
  } attr_t;

  function automatic logic is_acq(input FTk_t t);
    return t.v & t.a & ~t.r;
  endfunction

  function automatic logic is_rel(input FTk_t t);
    return t.v & t.a & t.r;
  endfunction

  // Attribute word: bit MSB = pull request, low WIDTH_LENGTH bits = Length
  function automatic attr_t attribute_dec(input logic [WIDTH_DATA-1:0] d);
    attr_t res;
    res.is_pull = d[WIDTH_DATA-1];
    res.length  = d[WIDTH_LENGTH-1:0];
    return res;
  endfunction

endpackage

// File: rtl/eram_resp_skid.sv
// rtl/eram_resp_skid.sv - small FTk_t FIFO holding the load-return stream
module eram_resp_skid
  import eram_resp_pkg::*;
#(
  parameter int DEPTH = SKID_DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  FTk_t          push_data,
  input  logic          pop,
  output FTk_t          head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  FTk_t          mem_q [DEPTH];
  FTk_t          mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy update; pop is ignored when empty
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    do_pop = pop & (cnt_q != '0);
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) rd_d = nxt(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

  // The read scheduler must never push into a full buffer without a pop
  assert property (@(posedge clock) disable iff (!reset)
    !(push && !do_pop && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/eram_resp.sv
// rtl/eram_resp.sv - ERAM-side responder: stores token streams to BRAM, returns loads
module eram_resp
  import eram_resp_pkg::*;
#(
  parameter int WIDTH_ADDR = 10,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  FTk_t                  I_FTk,
  output BTk_t                  O_BTk,
  output FTk_t                  O_FTk,
  input  BTk_t                  I_BTk,
  output logic                  O_Mem_Re,
  output logic                  O_Mem_We,
  output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0] O_Mem_WData,
  input  logic [WIDTH_DATA-1:0] I_Mem_RData,
  output logic                  O_Busy,
  output logic                  O_Err
);

  localparam int CW = $clog2(SKID_DEPTH + 1);

  fsm_eram_resp            state_q, state_d;
  logic [WIDTH_TID-1:0]    tid_q, tid_d;
  logic [WIDTH_DATA-1:0]   fid_q, fid_d;
  logic [WIDTH_LENGTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic                    pull_q, pull_d, err_q, err_d;
  logic [WIDTH_ADDR-1:0]   addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [WIDTH_DATA-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic                    re_last_q, re_last_d, rv_q, rv_last_q;

  logic          ld_phase, accept, acq_push, skid_pop, room, rd_issue;
  logic          skid_push;
  FTk_t          skid_wdata, skid_head;
  logic [CW-1:0] skid_count;
  logic [CW+1:0] occ;
  attr_t         attr;
  logic          unused_in;

  assign unused_in = ^{I_BTk.t, I_BTk.v, I_BTk.c, I_FTk.i};

  // Half-duplex: request input is held off for the whole load return
  assign ld_phase = (state_q == RESP_LD_ACQ) || (state_q == RESP_LD_DATA) ||
                    (state_q == RESP_LD_DRAIN);
  assign accept   = I_FTk.v & ~ld_phase;
  assign acq_push = (state_q == RESP_LD_ACQ);
  assign skid_pop = ~I_BTk.n & (skid_count != '0);
  assign attr     = attribute_dec(I_FTk.d);

  // A new read lands two cycles later; count everything already headed for the skid
  assign occ  = (CW+2)'(skid_count) + (CW+2)'(acq_push) + (CW+2)'(rv_q) + (CW+2)'(mem_re_q);
  assign room = occ < ((CW+2)'(SKID_DEPTH) + (CW+2)'(skid_pop));

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    tid_d       = tid_q;
    fid_d       = fid_q;
    len_d       = len_q;
    pull_d      = pull_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    err_d       = err_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    re_last_d   = 1'b0;
    rd_issue    = 1'b0;
    case (state_q)
      RESP_IDLE: if (accept) begin
        if (is_acq(I_FTk)) begin
          tid_d   = I_FTk.d[WIDTH_TID-1:0];
          state_d = RESP_FID;
        end else begin
          err_d = 1'b1;
        end
      end
      RESP_FID: if (accept) begin
        fid_d   = I_FTk.d;
        state_d = RESP_ATTR;
      end
      RESP_ATTR: if (accept) begin
        len_d   = attr.length;
        pull_d  = attr.is_pull;
        state_d = RESP_ROUTE;
      end
      RESP_ROUTE: if (accept) begin
        addr_d  = I_FTk.d[WIDTH_ADDR-1:0];
        cnt_d   = len_q;
        state_d = pull_q ? RESP_LD_ACQ : RESP_ST_DATA;
      end
      RESP_ST_DATA: if (accept) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = I_FTk.d;
        addr_d      = addr_q + 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (is_rel(I_FTk)) begin
          if (cnt_q != '0) err_d = 1'b1;
          state_d = RESP_IDLE;
        end else if (cnt_q == '0) begin
          err_d = 1'b1;
        end
      end
      // The first read already issues alongside the acquire word to hide BRAM latency
      RESP_LD_ACQ: begin
        rd_issue = room;
        state_d  = RESP_LD_DATA;
      end
      RESP_LD_DATA: rd_issue = room;
      RESP_LD_DRAIN:
        if (skid_count == '0 && !mem_re_q && !rv_q) state_d = RESP_IDLE;
      default: state_d = RESP_IDLE;
    endcase
    if (rd_issue) begin
      mem_re_d   = 1'b1;
      mem_addr_d = addr_q;
      addr_d     = addr_q + 1'b1;
      re_last_d  = (cnt_q == '0);
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else state_d = RESP_LD_DRAIN;
    end
  end

  // All state and BRAM-side outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RESP_IDLE;
      tid_q       <= '0;
      fid_q       <= '0;
      len_q       <= '0;
      pull_q      <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      re_last_q   <= 1'b0;
      rv_q        <= 1'b0;
      rv_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tid_q       <= tid_d;
      fid_q       <= fid_d;
      len_q       <= len_d;
      pull_q      <= pull_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      re_last_q   <= re_last_d;
      rv_q        <= mem_re_q;
      rv_last_q   <= mem_re_q & re_last_q;
    end
  end

  assign skid_push  = acq_push | rv_q;
  assign skid_wdata = acq_push ?
      '{v: 1'b1, a: 1'b1, r: 1'b0, i: tid_q, d: fid_q} :
      '{v: 1'b1, a: rv_last_q, r: rv_last_q, i: tid_q, d: I_Mem_RData};

  eram_resp_skid #(.DEPTH(SKID_DEPTH), .CW(CW)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (skid_push),
    .push_data (skid_wdata),
    .pop       (~I_BTk.n),
    .head      (skid_head),
    .count     (skid_count)
  );

  assign O_FTk       = (skid_count != '0) ? skid_head : '0;
  assign O_BTk       = '{n: ld_phase, t: 1'b0, v: 1'b0, c: 1'b0};
  assign O_Mem_Re    = mem_re_q;
  assign O_Mem_We    = mem_we_q;
  assign O_Mem_Addr  = mem_addr_q;
  assign O_Mem_WData = mem_wdata_q;
  assign O_Busy      = (state_q != RESP_IDLE);
  assign O_Err       = err_q;

endmodule

// File: tb/tb_eram_resp.sv
// tb/tb_eram_resp.sv - scoreboard bench for eram_resp
module tb_eram_resp;
  import eram_resp_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  FTk_t        I_FTk, O_FTk;
  BTk_t        I_BTk, O_BTk;
  logic        O_Mem_Re, O_Mem_We, O_Busy, O_Err;
  logic [9:0]  O_Mem_Addr;
  logic [31:0] O_Mem_WData, I_Mem_RData;

  eram_resp #(.WIDTH_ADDR(10), .SKID_DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_FTk       (I_FTk),
    .O_BTk       (O_BTk),
    .O_FTk       (O_FTk),
    .I_BTk       (I_BTk),
    .O_Mem_Re    (O_Mem_Re),
    .O_Mem_We    (O_Mem_We),
    .O_Mem_Addr  (O_Mem_Addr),
    .O_Mem_WData (O_Mem_WData),
    .I_Mem_RData (I_Mem_RData),
    .O_Busy      (O_Busy),
    .O_Err       (O_Err)
  );

  always #5 clock = ~clock;

  logic [31:0] bram [1024];
  always @(posedge clock) begin
    if (O_Mem_We) bram[O_Mem_Addr] <= O_Mem_WData;
    if (O_Mem_Re) I_Mem_RData <= bram[O_Mem_Addr];
  end

  logic [41:0] exp_wr [$];
  FTk_t        exp_ld [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] wbuf [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic miss(input string name, input logic [63:0] got);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing", name, got);
  endtask

  // Monitor: pops expected BRAM writes and load words as the DUT presents them
  FTk_t prev_ftk;
  logic prev_stall = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) chk("stall_hold", 64'(O_FTk), 64'(prev_ftk));
      if (O_Mem_We) begin
        if (exp_wr.size() == 0) miss("unexpected_write", {O_Mem_Addr, O_Mem_WData});
        else chk("bram_write", {O_Mem_Addr, O_Mem_WData}, exp_wr.pop_front());
      end
      if (O_FTk.v) begin
        chk("ld_btk_n", 64'(O_BTk.n), 64'd1);
        if (!I_BTk.n) begin
          if (exp_ld.size() == 0) miss("unexpected_load", 64'(O_FTk));
          else chk("load_word", 64'(O_FTk), 64'(exp_ld.pop_front()));
        end
      end
      prev_stall = O_FTk.v & I_BTk.n;
      prev_ftk   = O_FTk;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Drive one word at a negedge; returns at the negedge after it was accepted
  task automatic put(input logic a, input logic r, input logic [31:0] d);
    int k = 0;
    I_FTk = '{v: 1'b1, a: a, r: r, i: 8'h00, d: d};
    while (O_BTk.n && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (O_BTk.n) miss("put_timeout", 64'(d));
    @(negedge clock);
    I_FTk = '0;
  endtask

  task automatic head(input logic [7:0] tid, input logic [31:0] fid, input logic pull,
                      input logic [7:0] len, input logic [9:0] base);
    put(1'b1, 1'b0, {24'd0, tid});
    put(1'b0, 1'b0, fid);
    put(1'b0, 1'b0, {pull, 23'd0, len});
    put(1'b0, 1'b0, {22'd0, base});
  endtask

  // Store n words of wbuf; the last one is sent as release
  task automatic store(input logic [9:0] base, input logic [7:0] len, input int n);
    head(8'h05, 32'h2, 1'b0, len, base);
    for (int k = 0; k < n; k++) begin
      exp_wr.push_back({base + 10'(k), wbuf[k]});
      put(k == n - 1, k == n - 1, wbuf[k]);
    end
  endtask

  // Load len+1 words; expected data comes from wbuf
  task automatic load(input logic [7:0] tid, input logic [31:0] fid,
                      input logic [9:0] base, input logic [7:0] len);
    exp_ld.push_back('{v: 1'b1, a: 1'b1, r: 1'b0, i: tid, d: fid});
    for (int k = 0; k <= int'(len); k++)
      exp_ld.push_back('{v: 1'b1, a: (k == int'(len)), r: (k == int'(len)), i: tid, d: wbuf[k]});
    head(tid, fid, 1'b1, len, base);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!(exp_wr.size() == 0 && exp_ld.size() == 0 && !O_Busy) && k < 400) begin
      @(negedge clock);
      k++;
    end
    repeat (2) @(negedge clock);
    chk(name, 64'(exp_wr.size() + exp_ld.size() + int'(O_Busy)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_FTk = '0;
    I_BTk = '0;
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {58'd0, O_Mem_Re, O_Mem_We, O_Busy, O_Err, O_BTk.n, |O_BTk}, 64'd0);
    chk("rst_addr_wdata", {22'd0, O_Mem_Addr, O_Mem_WData}, 64'd0);
    chk("rst_ftk", 64'(O_FTk), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Store Length=3 at 0x010
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    store(10'h010, 8'd3, 4);
    wait_done("store_done");
    chk("store_err", 64'(O_Err), 64'd0);

    // Fill 0x020..0x022 with 7,8,9 then load them back
    wbuf[0] = 32'd7; wbuf[1] = 32'd8; wbuf[2] = 32'd9;
    store(10'h020, 8'd2, 3);
    wait_done("fill_done");
    load(8'h09, 32'h55, 10'h020, 8'd2);
    wait_done("load_done");
    chk("load_err", 64'(O_Err), 64'd0);

    // Load 0x010..0x013 with a 5-cycle stall mid-stream
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    load(8'h0C, 32'h66, 10'h010, 8'd3);
    repeat (3) @(posedge clock);
    #1 I_BTk.n = 1'b1;
    repeat (5) @(posedge clock);
    #1 I_BTk.n = 1'b0;
    wait_done("stall_load_done");

    // Address wrap on store and on load
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    exp_wr.push_back({10'h3FE, 32'h11});
    exp_wr.push_back({10'h3FF, 32'h22});
    exp_wr.push_back({10'h000, 32'h33});
    exp_wr.push_back({10'h001, 32'h44});
    head(8'h05, 32'h2, 1'b0, 8'd3, 10'h3FE);
    for (int k = 0; k < 4; k++) put(k == 3, k == 3, wbuf[k]);
    wait_done("wrap_store_done");
    load(8'h03, 32'h77, 10'h3FE, 8'd3);
    wait_done("wrap_load_done");
    chk("wrap_err", 64'(O_Err), 64'd0);

    // Early release: 2 of 4 words
    wbuf[0] = 32'hE1; wbuf[1] = 32'hE2;
    store(10'h100, 8'd3, 2);
    wait_done("early_rel_done");
    chk("early_rel_err", 64'(O_Err), 64'd1);
    chk("early_rel_idle", 64'(O_Busy), 64'd0);

    // Reset during RESP_LD_DATA
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    load(8'h0D, 32'h88, 10'h010, 8'd3);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst2_ctrl", {58'd0, O_Mem_Re, O_Mem_We, O_Busy, O_Err, O_BTk.n, |O_BTk}, 64'd0);
    chk("rst2_addr_wdata", {22'd0, O_Mem_Addr, O_Mem_WData}, 64'd0);
    chk("rst2_ftk", 64'(O_FTk), 64'd0);
    exp_ld.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    wbuf[0] = 32'h5A; wbuf[1] = 32'hA5;
    store(10'h200, 8'd1, 2);
    wait_done("post_rst_store_done");
    chk("post_rst_err", 64'(O_Err), 64'd0);
    load(8'h01, 32'h99, 10'h200, 8'd1);
    wait_done("post_rst_load_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
